cpu_state_dump_ctrl: RTL and testbench

Run-control and state-dump engine for the pipelined RISC-V CPU. It counts cycles from reset release and detects a stop condition: cycle timeout, an external halt request, or the PC stuck at one value. On a stop it freezes the core and streams every register-file word, then every data-memory word, over a valid/ready port. Synthesizable replacement for the fixed-cycle, bench-only RF/DMEM dump, with a configurable stop point, depth, width and stop modes.

---
 rtl/cpu_state_dump_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_state_dump_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_state_dump_ctrl
//  Purpose  : Run-control and state-dump engine for the pipelined RISC-V CPU.
//             Counts RUN cycles after reset release and watches for a stop
//             condition (external halt, PC stuck at one value, or cycle
//             timeout). On a stop it freezes the core, then streams every
//             register-file word followed by every data-memory word over a
//             valid/ready port. dump_done is sticky until reset.
//  Ports    : clk, reset_b (async active-low)
//             cfg_max_cycles  - timeout stop point, 0 disables
//             halt_req, pc    - stop request level / current fetch PC
//             cpu_stall       - freezes the core from FREEZE onward
//             rf_raddr/rf_rdata, dm_raddr/dm_rdata - combinational debug reads
//             dump_valid/dump_ready/dump_is_mem/dump_idx/dump_data - dump stream
//             dump_done, cycle_count, stop_cause - status
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_state_dump_ctrl #(
   parameter int XLEN        = 64,
   parameter int NUM_REGS    = 32,
   parameter int DMEM_DEPTH  = 8,
   parameter int CYC_W       = 16,
   parameter int PC_STABLE_N = 4,
   parameter int RF_AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter int DM_AW       = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1,
   parameter int IDX_W       = (RF_AW > DM_AW) ? RF_AW : DM_AW
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic [CYC_W-1:0] cfg_max_cycles,
   input  logic             halt_req,
   input  logic [XLEN-1:0]  pc,
   output logic             cpu_stall,
   output logic [RF_AW-1:0] rf_raddr,
   input  logic [XLEN-1:0]  rf_rdata,
   output logic [DM_AW-1:0] dm_raddr,
   input  logic [XLEN-1:0]  dm_rdata,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic             dump_is_mem,
   output logic [IDX_W-1:0] dump_idx,
   output logic [XLEN-1:0]  dump_data,
   output logic             dump_done,
   output logic [CYC_W-1:0] cycle_count,
   output logic [1:0]       stop_cause
);

   localparam int               SC_W          = $clog2(PC_STABLE_N + 1);
   localparam logic [IDX_W-1:0] C_RF_LAST     = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] C_DM_LAST     = IDX_W'(DMEM_DEPTH - 1);
   localparam logic [SC_W-1:0]  C_STABLE_LAST = SC_W'(PC_STABLE_N - 1);
   localparam logic [CYC_W-1:0] C_CYC_MAX     = '1;

   localparam logic [1:0] C_CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] C_CAUSE_HALT    = 2'b10;
   localparam logic [1:0] C_CAUSE_STABLE  = 2'b11;

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_FREEZE = 3'd1,
      S_LOAD   = 3'd2,
      S_SEND   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_q,   state_d;
   logic [CYC_W-1:0] cycle_q,   cycle_d;
   logic [SC_W-1:0]  stable_q,  stable_d;
   logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
   logic [IDX_W-1:0] ptr_q,     ptr_d;
   logic             is_mem_q,  is_mem_d;
   logic             stall_q,   stall_d;
   logic             valid_q,   valid_d;
   logic             done_q,    done_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [XLEN-1:0]  data_q,    data_d;
   logic [1:0]       cause_q,   cause_d;

   logic w_pc_same;
   logic w_trig_stable;
   logic w_trig_timeout;

   assign w_pc_same      = (pc == prev_pc_q);
   // Counter already holds PC_STABLE_N-1 repeats and this cycle repeats again.
   assign w_trig_stable  = w_pc_same && (stable_q == C_STABLE_LAST);
   // Fires in the last of cfg_max_cycles RUN cycles so the stop lands exactly on it.
   assign w_trig_timeout = (cfg_max_cycles != '0) &&
                           (cycle_q == (cfg_max_cycles - CYC_W'(1)));

   always_comb begin
      state_d   = state_q;
      cycle_d   = cycle_q;
      stable_d  = stable_q;
      prev_pc_d = prev_pc_q;
      ptr_d     = ptr_q;
      is_mem_d  = is_mem_q;
      stall_d   = stall_q;
      valid_d   = valid_q;
      done_d    = done_q;
      idx_d     = idx_q;
      data_d    = data_q;
      cause_d   = cause_q;

      case (state_q)
         S_RUN: begin
            cycle_d   = (cycle_q == C_CYC_MAX) ? cycle_q : cycle_q + CYC_W'(1);
            stable_d  = w_pc_same ? stable_q + SC_W'(1) : '0;
            prev_pc_d = pc;
            if (halt_req || w_trig_stable || w_trig_timeout) begin
               state_d = S_FREEZE;
               stall_d = 1'b1;
               if (halt_req)           cause_d = C_CAUSE_HALT;
               else if (w_trig_stable) cause_d = C_CAUSE_STABLE;
               else                    cause_d = C_CAUSE_TIMEOUT;
            end
         end
         S_FREEZE: begin
            // One idle cycle lets in-flight writebacks land before reading.
            ptr_d    = '0;
            is_mem_d = 1'b0;
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            data_d  = is_mem_q ? dm_rdata : rf_rdata;
            idx_d   = ptr_q;
            valid_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (dump_ready) begin
               valid_d = 1'b0;
               state_d = S_LOAD;
               if (!is_mem_q) begin
                  if (ptr_q == C_RF_LAST) begin
                     ptr_d    = '0;
                     is_mem_d = 1'b1;
                  end else begin
                     ptr_d = ptr_q + IDX_W'(1);
                  end
               end else if (ptr_q == C_DM_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= S_RUN;
         cycle_q   <= '0;
         stable_q  <= '0;
         prev_pc_q <= '0;
         ptr_q     <= '0;
         is_mem_q  <= 1'b0;
         stall_q   <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         cause_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         cycle_q   <= cycle_d;
         stable_q  <= stable_d;
         prev_pc_q <= prev_pc_d;
         ptr_q     <= ptr_d;
         is_mem_q  <= is_mem_d;
         stall_q   <= stall_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         cause_q   <= cause_d;
      end
   end

   // Both debug read ports follow the dump pointer; only one is consumed.
   assign rf_raddr    = ptr_q[RF_AW-1:0];
   assign dm_raddr    = ptr_q[DM_AW-1:0];
   assign cpu_stall   = stall_q;
   assign dump_valid  = valid_q;
   assign dump_is_mem = is_mem_q;
   assign dump_idx    = idx_q;
   assign dump_data   = data_q;
   assign dump_done   = done_q;
   assign cycle_count = cycle_q;
   assign stop_cause  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_state_dump_ctrl
//  Purpose  : Directed self-checking bench for cpu_state_dump_ctrl. A second
//             instance with a 4-bit cycle counter covers saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_state_dump_ctrl;

   localparam int XLEN       = 64;
   localparam int NUM_REGS   = 32;
   localparam int DMEM_DEPTH = 8;
   localparam int CYC_W      = 16;
   localparam int N_WORDS    = NUM_REGS + DMEM_DEPTH;

   logic             clk = 1'b0;
   logic             reset_b;
   logic [CYC_W-1:0] cfg_max_cycles;
   logic             halt_req;
   logic [XLEN-1:0]  pc;
   logic             cpu_stall;
   logic [4:0]       rf_raddr;
   logic [XLEN-1:0]  rf_rdata;
   logic [2:0]       dm_raddr;
   logic [XLEN-1:0]  dm_rdata;
   logic             dump_valid;
   logic             dump_ready;
   logic             dump_is_mem;
   logic [4:0]       dump_idx;
   logic [XLEN-1:0]  dump_data;
   logic             dump_done;
   logic [CYC_W-1:0] cycle_count;
   logic [1:0]       stop_cause;

   logic [3:0]       sat_cfg;
   logic             sat_stall;
   logic [4:0]       sat_rf_raddr;
   logic [2:0]       sat_dm_raddr;
   logic             sat_valid;
   logic             sat_is_mem;
   logic [4:0]       sat_idx;
   logic [XLEN-1:0]  sat_data;
   logic             sat_done;
   logic [3:0]       sat_count;
   logic [1:0]       sat_cause;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Register-file and data-memory contents as seen through the debug ports.
   function automatic logic [63:0] rf_word(input int i);
      return {32'h5EED_0000 + 32'(i), ~(32'h0000_1000 + 32'(i))};
   endfunction

   function automatic logic [63:0] dm_word(input int i);
      return {32'hD3E3_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 3)};
   endfunction

   assign rf_rdata = rf_word(int'(rf_raddr));
   assign dm_rdata = dm_word(int'(dm_raddr));

   cpu_state_dump_ctrl #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DMEM_DEPTH(DMEM_DEPTH),
      .CYC_W(CYC_W), .PC_STABLE_N(4)
   ) u_dut (
      .clk(clk), .reset_b(reset_b), .cfg_max_cycles(cfg_max_cycles),
      .halt_req(halt_req), .pc(pc), .cpu_stall(cpu_stall),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_is_mem(dump_is_mem), .dump_idx(dump_idx), .dump_data(dump_data),
      .dump_done(dump_done), .cycle_count(cycle_count), .stop_cause(stop_cause)
   );

   cpu_state_dump_ctrl #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DMEM_DEPTH(DMEM_DEPTH),
      .CYC_W(4), .PC_STABLE_N(4)
   ) u_sat (
      .clk(clk), .reset_b(reset_b), .cfg_max_cycles(sat_cfg),
      .halt_req(halt_req), .pc(pc), .cpu_stall(sat_stall),
      .rf_raddr(sat_rf_raddr), .rf_rdata(rf_rdata),
      .dm_raddr(sat_dm_raddr), .dm_rdata(dm_rdata),
      .dump_valid(sat_valid), .dump_ready(dump_ready),
      .dump_is_mem(sat_is_mem), .dump_idx(sat_idx), .dump_data(sat_data),
      .dump_done(sat_done), .cycle_count(sat_count), .stop_cause(sat_cause)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns after an edge in RUN cycle 0 (cycle_count == 0).
   task automatic do_reset();
      reset_b    = 1'b0;
      halt_req   = 1'b0;
      dump_ready = 1'b0;
      tick();
      tick();
      reset_b = 1'b1;
   endtask

   // Called in the first FREEZE cycle. Collects every transfer and returns the
   // number of cycles until dump_done is seen.
   task automatic run_dump(input bit bp, output int cyc);
      int  k    = 0;
      int  hold = 0;
      bit  fin  = 1'b0;
      cyc = 0;
      for (int n = 0; n < 400 && !fin; n++) begin
         if (dump_done) begin
            fin = 1'b1;
         end else begin
            if (bp && k == 7 && hold < 5 && (hold > 0 || dump_valid)) begin
               dump_ready = 1'b0;
               check("hold_valid",  64'(dump_valid),  64'd1);
               check("hold_idx",    64'(dump_idx),    64'd7);
               check("hold_is_mem", 64'(dump_is_mem), 64'd0);
               check("hold_data",   dump_data,        rf_word(7));
               hold++;
            end else begin
               dump_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (dump_valid && dump_ready) begin
               check("word_in_range", 64'(k < N_WORDS), 64'd1);
               if (k < NUM_REGS) begin
                  check("rf_is_mem", 64'(dump_is_mem), 64'd0);
                  check("rf_idx",    64'(dump_idx),    64'(k));
                  check("rf_data",   dump_data,        rf_word(k));
               end else begin
                  check("dm_is_mem", 64'(dump_is_mem), 64'd1);
                  check("dm_idx",    64'(dump_idx),    64'(k - NUM_REGS));
                  check("dm_data",   dump_data,        dm_word(k - NUM_REGS));
               end
               k++;
            end
            tick();
            cyc++;
         end
      end
      dump_ready = 1'b0;
      check("word_count", 64'(k), 64'(N_WORDS));
      check("dump_done",  64'(dump_done), 64'd1);
      if (bp) check("hold_cycles", 64'(hold), 64'd5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  found;

      reset_b        = 1'b0;
      halt_req       = 1'b0;
      dump_ready     = 1'b0;
      cfg_max_cycles = '0;
      sat_cfg        = '0;
      pc             = 64'h100;

      // ---------------- reset state ----------------
      tick();
      check("rst_stall",  64'(cpu_stall),   64'd0);
      check("rst_valid",  64'(dump_valid),  64'd0);
      check("rst_is_mem", 64'(dump_is_mem), 64'd0);
      check("rst_idx",    64'(dump_idx),    64'd0);
      check("rst_data",   dump_data,        64'd0);
      check("rst_done",   64'(dump_done),   64'd0);
      check("rst_count",  64'(cycle_count), 64'd0);
      check("rst_cause",  64'(stop_cause),  64'd0);
      check("rst_rfaddr", 64'(rf_raddr),    64'd0);
      check("rst_dmaddr", 64'(dm_raddr),    64'd0);

      // ---------------- timeout at 40 cycles ----------------
      cfg_max_cycles = 16'd40;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         pc = 64'h100 + 64'(4 * k);
         if (k == 39) begin
            check("to_stall_before", 64'(cpu_stall),   64'd0);
            check("to_count_before", 64'(cycle_count), 64'd39);
         end
         tick();
      end
      check("to_stall", 64'(cpu_stall),   64'd1);
      check("to_count", 64'(cycle_count), 64'd40);
      check("to_cause", 64'(stop_cause),  64'd1);
      run_dump(1'b0, cyc);
      check("to_dump_cycles", 64'(cyc), 64'd81);
      tick();
      tick();
      check("to_done_sticky",  64'(dump_done),   64'd1);
      check("to_stall_done",   64'(cpu_stall),   64'd1);
      check("to_valid_done",   64'(dump_valid),  64'd0);
      check("to_count_frozen", 64'(cycle_count), 64'd40);
      check("to_cause_hold",   64'(stop_cause),  64'd1);

      // ---------------- backpressure ----------------
      cfg_max_cycles = 16'd5;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         pc = 64'h200 + 64'(4 * k);
         tick();
      end
      check("bp_stall", 64'(cpu_stall), 64'd1);
      run_dump(1'b1, cyc);

      // ---------------- halt at cycle 10, timeout 11 ----------------
      cfg_max_cycles = 16'd11;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         pc       = 64'h300 + 64'(4 * k);
         halt_req = (k == 10);
         tick();
      end
      halt_req = 1'b0;
      check("halt_cause", 64'(stop_cause),  64'd2);
      check("halt_count", 64'(cycle_count), 64'd11);
      check("halt_stall", 64'(cpu_stall),   64'd1);

      // ---------------- halt + pc_stable + timeout on one cycle ----------------
      // pc constant from cycle 0 (previous PC resets to 0): the stable counter
      // reaches 3 in cycle 4 with a repeat, coinciding with timeout at 5.
      cfg_max_cycles = 16'd5;
      pc             = 64'h18;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         check("tri_stall_before", 64'(cpu_stall), 64'd0);
         halt_req = (k == 4);
         tick();
      end
      halt_req = 1'b0;
      check("tri_cause", 64'(stop_cause),  64'd2);
      check("tri_count", 64'(cycle_count), 64'd5);

      // ---------------- pc_stable + timeout ----------------
      do_reset();
      for (int k = 0; k < 5; k++) tick();
      check("dual_cause", 64'(stop_cause),  64'd3);
      check("dual_count", 64'(cycle_count), 64'd5);
      check("dual_stall", 64'(cpu_stall),   64'd1);

      // ---------------- pc_stable alone ----------------
      // pc = 0x18 from cycle 5; repeats in cycles 6,7,8 bring the counter to 3,
      // and the repeat in cycle 9 triggers.
      cfg_max_cycles = 16'd0;
      pc             = 64'h100;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         pc = (k < 5) ? 64'h100 + 64'(4 * k) : 64'h18;
         check("ps_stall_before", 64'(cpu_stall), 64'd0);
         tick();
      end
      check("ps_stall", 64'(cpu_stall),   64'd1);
      check("ps_cause", 64'(stop_cause),  64'd3);
      check("ps_count", 64'(cycle_count), 64'd10);

      // ---------------- timeout disabled, saturation ----------------
      cfg_max_cycles = 16'd0;
      sat_cfg        = 4'd0;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         pc = 64'h400 + 64'(4 * k);
         if (k == 15) check("sat_count_15", 64'(sat_count), 64'd15);
         tick();
      end
      check("sat_count_hold", 64'(sat_count),   64'd15);
      check("sat_stall",      64'(sat_stall),   64'd0);
      check("sat_cause",      64'(sat_cause),   64'd0);
      check("sat_valid",      64'(sat_valid),   64'd0);
      check("sat_done",       64'(sat_done),    64'd0);
      check("sat_is_mem",     64'(sat_is_mem),  64'd0);
      check("sat_idx",        64'(sat_idx),     64'd0);
      check("sat_data",       sat_data,         64'd0);
      check("sat_rfaddr",     64'(sat_rf_raddr), 64'd0);
      check("sat_dmaddr",     64'(sat_dm_raddr), 64'd0);
      check("nosat_count",    64'(cycle_count), 64'd20);
      check("nosat_stall",    64'(cpu_stall),   64'd0);

      // ---------------- asynchronous reset mid-dump ----------------
      cfg_max_cycles = 16'd3;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         pc = 64'h500 + 64'(4 * k);
         tick();
      end
      found = 1'b0;
      dump_ready = 1'b1;
      for (int n = 0; n < 200 && !found; n++) begin
         if (dump_valid && dump_is_mem && dump_idx == 5'd3) found = 1'b1;
         else tick();
      end
      check("mid_found", 64'(found), 64'd1);
      #2;
      reset_b = 1'b0;
      #1;
      check("mid_stall",  64'(cpu_stall),   64'd0);
      check("mid_valid",  64'(dump_valid),  64'd0);
      check("mid_is_mem", 64'(dump_is_mem), 64'd0);
      check("mid_idx",    64'(dump_idx),    64'd0);
      check("mid_data",   dump_data,        64'd0);
      check("mid_done",   64'(dump_done),   64'd0);
      check("mid_count",  64'(cycle_count), 64'd0);
      check("mid_cause",  64'(stop_cause),  64'd0);
      check("mid_rfaddr", 64'(rf_raddr),    64'd0);
      check("mid_dmaddr", 64'(dm_raddr),    64'd0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         pc = 64'h600 + 64'(4 * k);
         tick();
      end
      check("re_cause", 64'(stop_cause), 64'd1);
      run_dump(1'b0, cyc);
      check("re_dump_cycles", 64'(cyc), 64'd81);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
